score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 5, the score that ends a game (legal range 1..15).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 26, the number of BALL_CLOCK cycles the ball stays frozen after a goal (legal range 1..255).
REQ-003 The block SHALL have port BALL_CLOCK, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port RESET, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port miss_left, input, 1, a level that is high while the ball is past player 1's (left) paddle.
REQ-006 The block SHALL have port miss_right, input, 1, a level that is high while the ball is past player 2's (right) paddle.
REQ-007 The block SHALL have port new_game, input, 1, a start-new-game request that is sampled as a level.
REQ-008 The block SHALL have port goal_player_1, output, 1, a one-cycle pulse when player 1 scores a non-winning point.
REQ-009 The block SHALL have port goal_player_2, output, 1, a one-cycle pulse when player 2 scores a non-winning point.
REQ-010 The block SHALL have port win_player_1, output, 1, a one-cycle pulse when player 1 reaches WIN_SCORE.
REQ-011 The block SHALL have port win_player_2, output, 1, a one-cycle pulse when player 2 reaches WIN_SCORE.
REQ-012 The block SHALL have port score_1, output, 4, player 1's score.
REQ-013 The block SHALL have port score_2, output, 4, player 2's score.
REQ-014 The block SHALL have port ball_freeze, output, 1, which is high while the ball must not move.
REQ-015 The block SHALL have port serve_dir, output, 1, the serve direction: 0 = serve toward player 1, 1 = serve toward player 2.

Function
REQ-016 The block SHALL register miss_left and miss_right each cycle and detect a rising edge as current=1 and previous=0; a miss that stays high SHALL count once only.
REQ-017 The FSM SHALL have the states PLAY, HOLD and OVER, and SHALL update all outputs from registers.
REQ-018 In PLAY, a miss_left edge alone SHALL count a point for player 2, and a miss_right edge alone SHALL count a point for player 1.
REQ-019 In PLAY, edges on miss_left and miss_right in the same cycle SHALL be ignored: no point, no pulse, no state change.
REQ-020 When a point is counted, on the same edge the scorer's score SHALL increment by 1.
REQ-021 When a point is counted, serve_dir SHALL be set toward the conceding player (player 1 concedes -> 0; player 2 concedes -> 1).
REQ-022 If the new score is below WIN_SCORE, the matching goal_player_x SHALL be 1 for exactly one cycle, the hold counter SHALL load HOLD_CYCLES-1, and the state SHALL go to HOLD.
REQ-023 If the new score equals WIN_SCORE, only win_player_x SHALL pulse for one cycle, goal_player_x SHALL stay 0, and the state SHALL go to OVER.
REQ-024 Pulse latency SHALL be one cycle: a miss edge sampled at edge n produces the pulse and the score change visible after edge n+1.
REQ-025 At most one of the four pulse outputs SHALL be high in any cycle.
REQ-026 In HOLD, ball_freeze SHALL be 1, all miss edges SHALL be ignored (edge history still tracked), and the counter SHALL decrement each cycle.
REQ-027 When the HOLD counter is 0, the next edge SHALL go to PLAY with ball_freeze=0, so the freeze lasts exactly HOLD_CYCLES cycles.
REQ-028 In OVER, ball_freeze SHALL be 1, the scores SHALL be held, miss edges SHALL be ignored, and no pulses SHALL occur.
REQ-029 new_game=1 in any state SHALL have priority over miss edges: both scores go to 0, no pulse, counter loads HOLD_CYCLES-1, state goes to HOLD, and serve_dir is unchanged.
REQ-030 Scores SHALL never exceed WIN_SCORE; there is no wrap-around.

Reset
REQ-031 While RESET=1 at a rising edge, the state SHALL become PLAY, and score_1, score_2, all pulse outputs, ball_freeze and serve_dir SHALL become 0.
REQ-032 While RESET=1 at a rising edge, the edge-detect history and the hold counter SHALL become 0.
REQ-033 RESET SHALL take priority over new_game and miss inputs, including in the middle of HOLD or OVER.

Verification
REQ-034 A single-point scenario SHALL be covered: reset, then miss_right high for 3 cycles -> one goal_player_1 pulse one cycle later, score_1=1, serve_dir=1, and ball_freeze=1 for exactly 26 cycles.
REQ-035 A win scenario SHALL be covered: with WIN_SCORE=5, five spaced miss_left edges -> four goal_player_2 pulses then one win_player_2 pulse with no goal pulse, score_2=5, state OVER, and ball_freeze held at 1.
REQ-036 A simultaneous-miss scenario SHALL be covered: miss_left and miss_right rising in the same cycle in PLAY -> no pulse and both scores unchanged.
REQ-037 A miss-during-hold scenario SHALL be covered: a miss edge during HOLD -> ignored, with no pulse and no score change.
REQ-038 A new-game scenario SHALL be covered: new_game in OVER -> scores 0/0, HOLD for 26 cycles, then PLAY; new_game together with a miss edge -> no pulse.
REQ-039 A reset-during-hold scenario SHALL be covered: RESET asserted mid-HOLD -> next cycle ball_freeze=0, scores 0, state PLAY.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: pong scoring FSM with miss-edge detection, goal/win pulses and post-goal ball freeze.
// Ports:
//   BALL_CLOCK                   - clock, rising edge
//   RESET                        - synchronous active-high reset
//   miss_left / miss_right       - levels, high while ball is past left / right paddle
//   new_game                     - level, restarts the game (scores cleared, ball frozen)
//   goal_player_1/2              - one-cycle pulse on a non-winning point
//   win_player_1/2               - one-cycle pulse when a player reaches WIN_SCORE
//   score_1 / score_2            - player scores
//   ball_freeze                  - high while the ball must not move
//   serve_dir                    - 0 serves toward player 1, 1 toward player 2
module score_keeper #(
    parameter int WIN_SCORE   = 5,
    parameter int HOLD_CYCLES = 26
) (
    input  logic       BALL_CLOCK,
    input  logic       RESET,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       new_game,
    output logic       goal_player_1,
    output logic       goal_player_2,
    output logic       win_player_1,
    output logic       win_player_2,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       ball_freeze,
    output logic       serve_dir
);
    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    localparam logic [3:0] WIN       = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic       ml_cur_q, ml_prev_q, mr_cur_q, mr_prev_q;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] s1_q, s1_d, s2_q, s2_d;
    logic       g1_q, g1_d, g2_q, g2_d, w1_q, w1_d, w2_q, w2_d;
    logic       frz_q, frz_d, srv_q, srv_d;
    logic       hit_l, hit_r;

    // Edges are taken between two registered samples, so the FSM reacts one cycle after the input is sampled.
    assign hit_l = ml_cur_q & ~ml_prev_q;
    assign hit_r = mr_cur_q & ~mr_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        srv_d   = srv_q;
        g1_d    = 1'b0;
        g2_d    = 1'b0;
        w1_d    = 1'b0;
        w2_d    = 1'b0;
        if (new_game) begin
            s1_d    = 4'd0;
            s2_d    = 4'd0;
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
        end else begin
            case (state_q)
                PLAY: begin
                    // Simultaneous misses cancel: only a lone edge scores.
                    if (hit_r && !hit_l) begin
                        s1_d  = s1_q + 4'd1;
                        srv_d = 1'b1;
                        if (s1_d == WIN) begin
                            w1_d    = 1'b1;
                            state_d = OVER;
                        end else begin
                            g1_d    = 1'b1;
                            cnt_d   = HOLD_LOAD;
                            state_d = HOLD;
                        end
                    end else if (hit_l && !hit_r) begin
                        s2_d  = s2_q + 4'd1;
                        srv_d = 1'b0;
                        if (s2_d == WIN) begin
                            w2_d    = 1'b1;
                            state_d = OVER;
                        end else begin
                            g2_d    = 1'b1;
                            cnt_d   = HOLD_LOAD;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == 8'd0) state_d = PLAY;
                    else cnt_d = cnt_q - 8'd1;
                end
                OVER:    state_d = OVER;
                default: state_d = PLAY;
            endcase
        end
        frz_d = state_d != PLAY;
    end

    always_ff @(posedge BALL_CLOCK) begin
        if (RESET) begin
            state_q   <= PLAY;
            ml_cur_q  <= 1'b0;
            ml_prev_q <= 1'b0;
            mr_cur_q  <= 1'b0;
            mr_prev_q <= 1'b0;
            cnt_q     <= 8'd0;
            s1_q      <= 4'd0;
            s2_q      <= 4'd0;
            g1_q      <= 1'b0;
            g2_q      <= 1'b0;
            w1_q      <= 1'b0;
            w2_q      <= 1'b0;
            frz_q     <= 1'b0;
            srv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ml_cur_q  <= miss_left;
            ml_prev_q <= ml_cur_q;
            mr_cur_q  <= miss_right;
            mr_prev_q <= mr_cur_q;
            cnt_q     <= cnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            g1_q      <= g1_d;
            g2_q      <= g2_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            frz_q     <= frz_d;
            srv_q     <= srv_d;
        end
    end

    assign goal_player_1 = g1_q;
    assign goal_player_2 = g2_q;
    assign win_player_1  = w1_q;
    assign win_player_2  = w2_q;
    assign score_1       = s1_q;
    assign score_2       = s2_q;
    assign ball_freeze   = frz_q;
    assign serve_dir     = srv_q;
endmodule
